adpll_loop_ctrl: RTL and testbench
==================================

// Module: adpll_loop_ctrl
// PURPOSE
//  Digital loop controller for the ADPLL. Samples the PFD flagU/flagD outputs,
//  runs a binary-search frequency acquisition, then +/-1 phase tracking on the
//  DCO control word, and declares lock. Sits between the PFD and the DCO code input.
// PARAMETERS
//  CODE_W    8   DCO control word width
//  SETTLE    4   clk cycles per decision (DCO/PFD settle time); must be >= 1
//  LOCK_CNT  16  consecutive "good" decisions required to assert lock
//  LOSS_CNT  8   consecutive same-direction decisions that drop lock (macro only)
// PORTS
//  clk       in   1       controller clock
//  reset     in   1       synchronous, active-high reset
//  enable    in   1       1 = run loop; 0 = return to IDLE
//  flag_up   in   1       PFD flagU, asynchronous; FB lags, so raise DCO frequency
//  flag_dn   in   1       PFD flagD, asynchronous; FB leads, so lower DCO frequency
//  dco_code  out  CODE_W  DCO control word, registered
//  code_upd  out  1       one-cycle pulse in the cycle after dco_code changes
//  lock      out  1       loop locked
//  state     out  2       0=IDLE 1=BSEARCH 2=TRACK 3=LOCKED
// BEHAVIOUR
//  - Reset: dco_code = 2^(CODE_W-1) (midscale), code_upd=0, lock=0, state=IDLE,
//    all counters 0.
//  - flag_up and flag_dn each pass through a 2-FF synchronizer (up_s, dn_s). A
//    decision samples up_s/dn_s in the last cycle of each SETTLE window:
//    UP = up_s&!dn_s; DN = dn_s&!up_s; HOLD otherwise, including 1/1.
//  - The settle counter reloads to SETTLE-1 on entry to BSEARCH and after every decision.
//  - IDLE: dco_code held at midscale. enable=1 -> BSEARCH next cycle, bit index
//    k=CODE_W-1, dco_code unchanged (bit k already set).
//  - BSEARCH: at each decision, DN clears bit k; UP/HOLD keeps it. If k>0, set
//    bit k-1 and decrement k in the same update. If k==0, go to TRACK.
//    Exactly CODE_W decisions, CODE_W*SETTLE cycles.
//  - TRACK: at each decision, UP -> code+1 and DN -> code-1, saturating at
//    2^CODE_W-1 / 0 (saturated: code unchanged, direction still recorded). HOLD -> no change.
//    good_cnt increments on HOLD or on a direction opposite to the last non-HOLD
//    decision. It clears on a repeat of the same direction. The first non-HOLD
//    decision in TRACK counts as good.
//    good_cnt==LOCK_CNT -> LOCKED; lock=1 in the same edge as the state change.
//  - LOCKED: code updates exactly as in TRACK. Exit is defined under CONFIGURATION.
//  - enable=0 in any state: next edge state=IDLE, lock=0, dco_code=midscale,
//    counters cleared. reset mid-operation behaves identically.
//  - code_upd=1 for exactly one cycle after any dco_code change, including the
//    return to midscale. It is never asserted if the value is unchanged.
// CONFIGURATION
//  - ADPLL_LOCK_LOSS_EN defined: LOCKED tracks a same-direction run counter.
//    Run counter reaches LOSS_CNT -> lock=0, state=TRACK, good_cnt=0.
//  - ADPLL_LOCK_LOSS_EN undefined: LOCKED is exited only by enable=0 or reset.
//    The run counter is not built.
// TESTING
//  1 reset=1, then enable=0 -> dco_code=0x80, lock=0, state=0, code_upd=0.
//  2 enable=1, flags model DCO target 0x5B (UP if code<target, DN if code>target)
//    -> BSEARCH ends with dco_code=0x5B after 8 decisions (32 clk), state=2.
//  3 From test 2, target alternates +/-1 around 0x5B -> lock=1 and state=3
//    after the 16th good decision.
//  4 At code 0xFF with flag_up held 1 -> dco_code stays 0xFF, no code_upd.
//    Same check at 0x00 with flag_dn held 1.
//  5 Locked, then flag_up held 1 for 8 decisions -> with ADPLL_LOCK_LOSS_EN:
//    lock=0 and state=2 after the 8th; without it: lock stays 1.
//  6 enable dropped mid-BSEARCH -> next edge state=0, dco_code=0x80, code_upd
//    pulses once.

Source files
------------

// File: rtl/adpll_loop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adpll_loop_ctrl
//  Description : Digital loop controller for the ADPLL. Sits between the PFD
//                and the DCO code input. Synchronizes the PFD flagU/flagD
//                outputs, runs a binary-search frequency acquisition, then
//                +/-1 phase tracking on the DCO control word, and declares
//                lock after LOCK_CNT consecutive good decisions.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CODE_W    DCO control word width
//    SETTLE    clk cycles per decision (DCO/PFD settle time), >= 1
//    LOCK_CNT  consecutive good decisions required to assert lock
//    LOSS_CNT  consecutive same-direction decisions that drop lock
//              (only used when ADPLL_LOCK_LOSS_EN is defined)
//  Ports
//    clk       in   1       controller clock
//    reset     in   1       synchronous, active-high reset
//    enable    in   1       1 = run loop, 0 = return to IDLE
//    flag_up   in   1       PFD flagU (async): raise DCO frequency
//    flag_dn   in   1       PFD flagD (async): lower DCO frequency
//    dco_code  out  CODE_W  DCO control word, registered
//    code_upd  out  1       one-cycle pulse alongside each dco_code change
//    lock      out  1       loop locked
//    state     out  2       0=IDLE 1=BSEARCH 2=TRACK 3=LOCKED
//  Build option
//    ADPLL_LOCK_LOSS_EN  when defined, LOCKED counts same-direction runs and
//                        falls back to TRACK after LOSS_CNT of them. When
//                        undefined, LOCKED is left only via enable=0/reset.
// ============================================================================
module adpll_loop_ctrl #(
    parameter int CODE_W   = 8,
    parameter int SETTLE   = 4,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flag_up,
    input  logic              flag_dn,
    output logic [CODE_W-1:0] dco_code,
    output logic              code_upd,
    output logic              lock,
    output logic [1:0]        state
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_BSEARCH = 2'd1;
    localparam logic [1:0] c_ST_TRACK   = 2'd2;
    localparam logic [1:0] c_ST_LOCKED  = 2'd3;

    localparam int c_K_W    = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int c_SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int c_GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CODE_W-1:0]   c_MID       = CODE_W'(1) << (CODE_W - 1);
    localparam logic [CODE_W-1:0]   c_MAX       = '1;
    localparam logic [CODE_W-1:0]   c_MIN       = '0;
    localparam logic [c_SET_W-1:0]  c_SET_RLD   = c_SET_W'(SETTLE - 1);
    localparam logic [c_K_W-1:0]    c_K_TOP     = c_K_W'(CODE_W - 1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_LOCK = c_GOOD_W'(LOCK_CNT);

    // Illegal parameter combinations leave an empty marker scope in the
    // elaborated hierarchy; the loop itself assumes SETTLE, LOCK_CNT and
    // LOSS_CNT are all at least 1.
    if (SETTLE < 1 || LOCK_CNT < 1 || LOSS_CNT < 1) begin : g_bad_params
    end

    // ------------------------------------------------------------------------
    // PFD flag synchronizers (2-FF each)
    // ------------------------------------------------------------------------
    logic r_up_meta;
    logic r_up_s;
    logic r_dn_meta;
    logic r_dn_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_up_meta <= 1'b0;
            r_up_s    <= 1'b0;
            r_dn_meta <= 1'b0;
            r_dn_s    <= 1'b0;
        end else begin
            r_up_meta <= flag_up;
            r_up_s    <= r_up_meta;
            r_dn_meta <= flag_dn;
            r_dn_s    <= r_dn_meta;
        end
    end

    // Decision decode: both flags high (or both low) is a HOLD.
    logic w_dec_up;
    logic w_dec_dn;
    assign w_dec_up = r_up_s & ~r_dn_s;
    assign w_dec_dn = r_dn_s & ~r_up_s;

    // ------------------------------------------------------------------------
    // Loop state and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [CODE_W-1:0]   r_code;
    logic                r_code_upd;
    logic [c_K_W-1:0]    r_k;          // bit under trial in BSEARCH
    logic [c_SET_W-1:0]  r_settle;     // cycles left in the settle window
    logic [c_GOOD_W-1:0] r_good;       // consecutive good decisions in TRACK
    logic                r_last_up;    // direction of last non-HOLD decision
    logic                r_have_dir;   // r_last_up is meaningful

    logic [1:0]          w_state_nxt;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [c_K_W-1:0]    w_k_nxt;
    logic [c_SET_W-1:0]  w_settle_nxt;
    logic [c_GOOD_W-1:0] w_good_nxt;
    logic                w_last_up_nxt;
    logic                w_have_dir_nxt;

`ifdef ADPLL_LOCK_LOSS_EN
    localparam int                  c_LOSS_W = $clog2(LOSS_CNT + 1);
    localparam logic [c_LOSS_W-1:0] c_LOSS   = c_LOSS_W'(LOSS_CNT);

    logic [c_LOSS_W-1:0] r_run;        // same-direction run length in LOCKED
    logic [c_LOSS_W-1:0] w_run_nxt;
`endif

    // A direction decision that repeats the previous non-HOLD direction.
    logic w_dir;
    logic w_repeat;
    assign w_dir    = w_dec_up | w_dec_dn;
    assign w_repeat = w_dir & r_have_dir & (r_last_up == w_dec_up);

    // ------------------------------------------------------------------------
    // State register (datapath registered alongside the state)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_code     <= c_MID;
            r_code_upd <= 1'b0;
            r_k        <= '0;
            r_settle   <= '0;
            r_good     <= '0;
            r_last_up  <= 1'b0;
            r_have_dir <= 1'b0;
`ifdef ADPLL_LOCK_LOSS_EN
            r_run      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            // Pulse accompanies the new code value for exactly one cycle.
            r_code_upd <= (w_code_nxt != r_code);
            r_k        <= w_k_nxt;
            r_settle   <= w_settle_nxt;
            r_good     <= w_good_nxt;
            r_last_up  <= w_last_up_nxt;
            r_have_dir <= w_have_dir_nxt;
`ifdef ADPLL_LOCK_LOSS_EN
            r_run      <= w_run_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_k_nxt        = r_k;
        w_settle_nxt   = r_settle;
        w_good_nxt     = r_good;
        w_last_up_nxt  = r_last_up;
        w_have_dir_nxt = r_have_dir;
`ifdef ADPLL_LOCK_LOSS_EN
        w_run_nxt      = r_run;
`endif

        if (!enable) begin
            // Disable from any state: back to midscale with counters cleared.
            w_state_nxt    = c_ST_IDLE;
            w_code_nxt     = c_MID;
            w_k_nxt        = '0;
            w_settle_nxt   = '0;
            w_good_nxt     = '0;
            w_last_up_nxt  = 1'b0;
            w_have_dir_nxt = 1'b0;
`ifdef ADPLL_LOCK_LOSS_EN
            w_run_nxt      = '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // Midscale already has the MSB set, so the first trial
                    // bit needs no code change on entry.
                    w_state_nxt  = c_ST_BSEARCH;
                    w_code_nxt   = c_MID;
                    w_k_nxt      = c_K_TOP;
                    w_settle_nxt = c_SET_RLD;
                end

                c_ST_BSEARCH: begin
                    if (r_settle != '0) begin
                        w_settle_nxt = r_settle - 1'b1;
                    end else begin
                        w_settle_nxt = c_SET_RLD;
                        // DCO too fast: the trial bit was too much.
                        if (w_dec_dn) begin
                            w_code_nxt[r_k] = 1'b0;
                        end
                        if (r_k != '0) begin
                            w_code_nxt[r_k - 1'b1] = 1'b1;
                            w_k_nxt                = r_k - 1'b1;
                        end else begin
                            w_state_nxt = c_ST_TRACK;
                        end
                    end
                end

                default: begin  // TRACK and LOCKED share the code update
                    if (r_settle != '0) begin
                        w_settle_nxt = r_settle - 1'b1;
                    end else begin
                        w_settle_nxt = c_SET_RLD;

                        // Saturating +/-1 step; direction is recorded even
                        // when the code is pinned at a rail.
                        if (w_dec_up) begin
                            if (r_code != c_MAX) begin
                                w_code_nxt = r_code + 1'b1;
                            end
                        end else if (w_dec_dn) begin
                            if (r_code != c_MIN) begin
                                w_code_nxt = r_code - 1'b1;
                            end
                        end

                        if (w_dir) begin
                            w_last_up_nxt  = w_dec_up;
                            w_have_dir_nxt = 1'b1;
                        end

                        if (r_state == c_ST_TRACK) begin
                            // HOLD or a reversal means the loop is dithering
                            // around the target; a repeat means it is still
                            // slewing.
                            if (w_repeat) begin
                                w_good_nxt = '0;
                            end else begin
                                w_good_nxt = r_good + 1'b1;
                            end
                            if (w_good_nxt == c_GOOD_LOCK) begin
                                w_state_nxt = c_ST_LOCKED;
                            end
                        end else begin
`ifdef ADPLL_LOCK_LOSS_EN
                            // A run of same-direction corrections means the
                            // reference has drifted away from the lock point.
                            if (!w_dir) begin
                                w_run_nxt = '0;
                            end else if (w_repeat) begin
                                w_run_nxt = r_run + 1'b1;
                            end else begin
                                w_run_nxt = c_LOSS_W'(1);
                            end
                            if (w_run_nxt == c_LOSS) begin
                                w_state_nxt = c_ST_TRACK;
                                w_good_nxt  = '0;
                                w_run_nxt   = '0;
                            end
`endif
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    always_comb begin
        dco_code = r_code;
        code_upd = r_code_upd;
        lock     = (r_state == c_ST_LOCKED);
        state    = r_state;
    end

endmodule
`default_nettype wire

// File: tb/tb_adpll_loop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adpll_loop_ctrl
//  Description : Directed self-checking bench for adpll_loop_ctrl
//                (CODE_W=8, SETTLE=4, LOCK_CNT=16, LOSS_CNT=8). Lock-loss
//                expectations follow ADPLL_LOCK_LOSS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adpll_loop_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       flag_up;
    logic       flag_dn;
    logic [7:0] dco_code;
    logic       code_upd;
    logic       lock;
    logic [1:0] state;

    int   n_pass = 0;
    int   n_fail = 0;
    int   n_chk  = 0;
    logic upd_any;

    adpll_loop_ctrl #(
        .CODE_W   (8),
        .SETTLE   (4),
        .LOCK_CNT (16),
        .LOSS_CNT (8)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .flag_up  (flag_up),
        .flag_dn  (flag_dn),
        .dco_code (dco_code),
        .code_upd (code_upd),
        .lock     (lock),
        .state    (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1ns after the rising edge and record any update pulse.
    task automatic clk1();
        @(posedge clk);
        #1;
        upd_any = upd_any | code_upd;
    endtask

    // One full settle window with fixed flags; ends just after the decision edge.
    task automatic decide(input logic u, input logic d);
        flag_up = u;
        flag_dn = d;
        upd_any = 1'b0;
        repeat (4) clk1();
    endtask

    // PFD plant: DCO target frequency represented as a code.
    task automatic decide_plant(input logic [7:0] tgt);
        decide(dco_code < tgt, dco_code > tgt);
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        flag_up = 1'b0;
        flag_dn = 1'b0;
        upd_any = 1'b0;

        // ---- reset state ----
        repeat (3) clk1();
        check("rst_code",  dco_code, 32'h80);
        check("rst_lock",  lock,     32'h0);
        check("rst_state", state,    32'h0);
        check("rst_upd",   code_upd, 32'h0);
        reset = 1'b0;
        clk1();
        check("idle_state", state,    32'h0);
        check("idle_code",  dco_code, 32'h80);

        // ---- binary search towards 0x5B ----
        enable = 1'b1;
        clk1();
        check("bs_entry_state", state,    32'h1);
        check("bs_entry_code",  dco_code, 32'h80);
        decide_plant(8'h5B);
        check("bs_first_code", dco_code, 32'h40);
        check("bs_first_upd",  code_upd, 32'h1);
        repeat (7) decide_plant(8'h5B);
        check("bs_end_code",  dco_code, 32'h5B);
        check("bs_end_state", state,    32'h2);
        check("bs_end_upd",   upd_any,  32'h0);

        // ---- alternating tracking up to lock ----
        for (int i = 1; i <= 15; i++) begin
            decide(i[0], ~i[0]);
        end
        check("trk15_state", state,    32'h2);
        check("trk15_lock",  lock,     32'h0);
        check("trk15_code",  dco_code, 32'h5C);
        decide(1'b0, 1'b1);
        check("lock_state", state,    32'h3);
        check("lock_lock",  lock,     32'h1);
        check("lock_code",  dco_code, 32'h5B);

        // ---- sustained UP while locked ----
        repeat (7) decide(1'b1, 1'b0);
        check("run7_lock", lock,     32'h1);
        check("run7_code", dco_code, 32'h62);
        decide(1'b1, 1'b0);
        check("run8_code", dco_code, 32'h63);
`ifdef ADPLL_LOCK_LOSS_EN
        check("run8_lock",  lock,  32'h0);
        check("run8_state", state, 32'h2);
`else
        check("run8_lock",  lock,  32'h1);
        check("run8_state", state, 32'h3);
`endif

        // ---- disable from locked/tracking ----
        enable = 1'b0;
        upd_any = 1'b0;
        clk1();
        check("dis_state", state,    32'h0);
        check("dis_code",  dco_code, 32'h80);
        check("dis_lock",  lock,     32'h0);
        check("dis_upd",   code_upd, 32'h1);
        clk1();
        check("dis_upd_end", code_upd, 32'h0);

        // ---- saturation at 0xFF ----
        enable = 1'b1;
        clk1();
        repeat (8) decide(1'b1, 1'b0);
        check("top_bs_code",  dco_code, 32'hFF);
        check("top_bs_state", state,    32'h2);
        decide(1'b1, 1'b0);
        check("top_sat_code", dco_code, 32'hFF);
        check("top_sat_upd",  upd_any,  32'h0);

        // ---- saturation at 0x00 ----
        enable = 1'b0;
        clk1();
        enable = 1'b1;
        clk1();
        repeat (8) decide(1'b0, 1'b1);
        check("bot_bs_code", dco_code, 32'h00);
        decide(1'b0, 1'b1);
        check("bot_sat_code",  dco_code, 32'h00);
        check("bot_sat_upd",   upd_any,  32'h0);
        check("bot_sat_state", state,    32'h2);
        decide(1'b1, 1'b1);
        check("hold_both_code", dco_code, 32'h00);

        // ---- enable dropped mid-search ----
        enable = 1'b0;
        clk1();
        enable = 1'b1;
        clk1();
        repeat (2) decide_plant(8'h5B);
        check("mid_bs_code",  dco_code, 32'h60);
        check("mid_bs_state", state,    32'h1);
        enable = 1'b0;
        upd_any = 1'b0;
        clk1();
        check("abort_state", state,    32'h0);
        check("abort_code",  dco_code, 32'h80);
        check("abort_upd",   code_upd, 32'h1);
        clk1();
        check("abort_upd_end", code_upd, 32'h0);
        check("abort_state2",  state,    32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
